t06_move_sequencer: RTL and testbench

//  Per-game-tick controller for the snake datapath. Each tick it pulses check_enable into
//  t06_collisionDetector, evaluates the registered collision flags, then sequences:
//  - the body shift/grow,
//  - apple respawn requests to the apple generator,
//  - game-over/win.

---
 rtl/t06_move_sequencer.sv | 162 ++++++++++++++++
 tb/tb_t06_move_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/t06_move_sequencer.sv
// Per-tick snake move sequencer: collision check, shift/grow, apple respawn, game end.
// Ports: clk/nrst, start/tick pulses, detector flags, apple_ack -> strobes, level status, length.
module t06_move_sequencer #(
  parameter int MAX_LENGTH  = 30,
  parameter int INIT_LENGTH = 2
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       start,
  input  logic       tick,
  input  logic       badCollision,
  input  logic       goodCollision,
  input  logic       good_collision2,
  input  logic       apple_ack,
  output logic       check_enable,
  output logic       init_body,
  output logic       move_en,
  output logic       grow,
  output logic       apple_req,
  output logic       apple_sel,
  output logic [4:0] length,
  output logic       game_over,
  output logic       win,
  output logic       tick_overrun
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_EVAL  = 3'd4;
  localparam logic [2:0] S_MOVE  = 3'd5;
  localparam logic [2:0] S_RESP  = 3'd6;
  localparam logic [2:0] S_OVER  = 3'd7;

  localparam logic [5:0] MAX_L  = 6'(MAX_LENGTH);
  localparam logic [4:0] INIT_L = 5'(INIT_LENGTH);

  logic [2:0] state_q, state_d;
  logic [4:0] len_q, len_d;
  logic       hit1_q, hit1_d;
  logic       hit2_q, hit2_d;
  logic       win_q, win_d;
  logic       ovr_q, ovr_d;

  logic [5:0] len_sum;
  logic [4:0] len_sat;
  logic       busy;

  // One extra bit so two hits near the top cannot wrap before saturation.
  always_comb begin
    len_sum = {1'b0, len_q}
            + {5'd0, hit1_q}
            + {5'd0, hit2_q};
    len_sat = (len_sum >= MAX_L) ? MAX_L[4:0]
                                 : len_sum[4:0];
  end

  // States in which a tick means the step is too short.
  assign busy = (state_q == S_CHECK) ||
                (state_q == S_EVAL)  ||
                (state_q == S_MOVE)  ||
                (state_q == S_RESP);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    hit1_d  = hit1_q;
    hit2_d  = hit2_q;
    win_d   = win_q;
    ovr_d   = ovr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_INIT;
      end
      S_INIT: begin
        len_d   = INIT_L;
        hit1_d  = 1'b0;
        hit2_d  = 1'b0;
        win_d   = 1'b0;
        ovr_d   = 1'b0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (start)     state_d = S_INIT;
        else if (tick) state_d = S_CHECK;
      end
      S_CHECK: begin
        state_d = S_EVAL;
      end
      S_EVAL: begin
        hit1_d  = goodCollision;
        hit2_d  = good_collision2;
        state_d = badCollision ? S_OVER
                               : S_MOVE;
      end
      S_MOVE: begin
        len_d = len_sat;
        if ({1'b0, len_sat} == MAX_L) begin
          win_d   = 1'b1;
          state_d = S_OVER;
        end else if (hit1_q || hit2_q) begin
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        // Apple 1 is always served before apple 2.
        if (apple_ack) begin
          if (hit1_q) begin
            hit1_d = 1'b0;
            if (!hit2_q) state_d = S_WAIT;
          end else begin
            hit2_d  = 1'b0;
            state_d = S_WAIT;
          end
        end
      end
      S_OVER: begin
        if (start) state_d = S_INIT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (tick && busy) ovr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      len_q   <= INIT_L;
      hit1_q  <= 1'b0;
      hit2_q  <= 1'b0;
      win_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      hit1_q  <= hit1_d;
      hit2_q  <= hit2_d;
      win_q   <= win_d;
      ovr_q   <= ovr_d;
    end
  end

  // Moore outputs decoded straight from registered state.
  assign check_enable = (state_q == S_CHECK);
  assign init_body    = (state_q == S_INIT);
  assign move_en      = (state_q == S_MOVE);
  assign grow         = move_en
                      && (hit1_q || hit2_q)
                      && ({1'b0, len_q} < MAX_L);
  assign apple_req    = (state_q == S_RESP);
  assign apple_sel    = apple_req && !hit1_q;
  assign length       = len_q;
  assign game_over    = (state_q == S_OVER);
  assign win          = win_q;
  assign tick_overrun = ovr_q;

endmodule

// File: tb/tb_t06_move_sequencer.sv
// Bench for t06_move_sequencer: table of game steps plus hand sequences.
// Two instances (MAX 30 and MAX 4) share stimulus through a select bit.
module tb_t06_move_sequencer;

  typedef struct {
    bit bad; bit g1; bit g2;
    bit mv; bit grow; int len;
    bit over; bit win; int nreq;
  } vec_t;

  logic clk = 0;
  logic nrst = 0;
  logic start = 0, tick = 0, bad = 0;
  logic g1 = 0, g2 = 0, ack = 0;
  logic sel2 = 0;

  logic c1, i1, m1, gr1, r1, s1, o1, w1, v1;
  logic c2, i2, m2, gr2, r2, s2, o2, w2, v2;
  logic [4:0] l1, l2;

  always #5 clk = ~clk;

  t06_move_sequencer #(.MAX_LENGTH(30), .INIT_LENGTH(2)) u1 (
    .clk(clk), .nrst(nrst),
    .start(start && !sel2), .tick(tick && !sel2),
    .badCollision(bad && !sel2),
    .goodCollision(g1 && !sel2),
    .good_collision2(g2 && !sel2),
    .apple_ack(ack && !sel2),
    .check_enable(c1), .init_body(i1),
    .move_en(m1), .grow(gr1),
    .apple_req(r1), .apple_sel(s1),
    .length(l1), .game_over(o1),
    .win(w1), .tick_overrun(v1)
  );

  t06_move_sequencer #(.MAX_LENGTH(4), .INIT_LENGTH(2)) u2 (
    .clk(clk), .nrst(nrst),
    .start(start && sel2), .tick(tick && sel2),
    .badCollision(bad && sel2),
    .goodCollision(g1 && sel2),
    .good_collision2(g2 && sel2),
    .apple_ack(ack && sel2),
    .check_enable(c2), .init_body(i2),
    .move_en(m2), .grow(gr2),
    .apple_req(r2), .apple_sel(s2),
    .length(l2), .game_over(o2),
    .win(w2), .tick_overrun(v2)
  );

  logic o_chk, o_init, o_mv, o_grow;
  logic o_req, o_sel, o_ov, o_win, o_ovr;
  logic [4:0] o_len;

  assign o_chk  = sel2 ? c2  : c1;
  assign o_init = sel2 ? i2  : i1;
  assign o_mv   = sel2 ? m2  : m1;
  assign o_grow = sel2 ? gr2 : gr1;
  assign o_req  = sel2 ? r2  : r1;
  assign o_sel  = sel2 ? s2  : s1;
  assign o_ov   = sel2 ? o2  : o1;
  assign o_win  = sel2 ? w2  : w1;
  assign o_ovr  = sel2 ? v2  : v1;
  assign o_len  = sel2 ? l2  : l1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input int act,
                     input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d @%0t",
               nm, act, want, $time);
    end
  endtask

  // Scoreboard: one entry per step, popped at move_en or at a
  // game_over that was not preceded by a move.
  vec_t sb[$];
  vec_t cur;
  bit chk_nx = 0;
  bit prev_mv = 0;
  bit prev_ov = 0;
  bit mon_on = 0;

  always @(negedge clk) begin
    if (mon_on) begin
      if (chk_nx) begin
        chk_nx = 0;
        chk("len", o_len, cur.len);
        chk("over", o_ov, cur.over);
        chk("win", o_win, cur.win);
        chk("req_after_move", o_req, int'(cur.nreq > 0));
      end
      if (o_mv || (o_ov && !prev_ov && !prev_mv)) begin
        if (sb.size() == 0) begin
          chk("sb_nonempty", sb.size(), 1);
        end else begin
          cur = sb.pop_front();
          chk("move_en", o_mv, cur.mv);
          if (o_mv) begin
            chk("grow", o_grow, cur.grow);
            chk_nx = 1;
          end else begin
            chk("len_over", o_len, cur.len);
            chk("win_over", o_win, cur.win);
            chk("req_over", o_req, 0);
          end
        end
      end
    end
    prev_mv = o_mv;
    prev_ov = o_ov;
  end

  task automatic run_step(input vec_t v,
                          input bit ovr,
                          input bit rst_in);
    bit exp_sel[$];
    int n;
    if (v.nreq > 0 && v.g1) exp_sel.push_back(1'b0);
    if (v.nreq > 0 && v.g2) exp_sel.push_back(1'b1);
    sb.push_back(v);
    @(negedge clk) tick = 1;
    @(negedge clk) tick = 0;
    chk("check_en", o_chk, 1);
    @(negedge clk);
    bad = v.bad; g1 = v.g1; g2 = v.g2;
    @(negedge clk);
    bad = 0; g1 = 0; g2 = 0;
    foreach (exp_sel[k]) begin
      n = 0;
      while (!o_req && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk("req_seen", o_req, 1);
      chk("sel", o_sel, exp_sel[k]);
      if (rst_in) begin
        #2 nrst = 0;
        #1;
        chk("rst_req", o_req, 0);
        chk("rst_sel", o_sel, 0);
        chk("rst_mv", o_mv, 0);
        chk("rst_ov", o_ov, 0);
        chk("rst_ovr", o_ovr, 0);
        chk("rst_len", o_len, 2);
        @(negedge clk) nrst = 1;
        return;
      end
      @(negedge clk);
      chk("req_hold", o_req, 1);
      chk("sel_hold", o_sel, exp_sel[k]);
      if (ovr) begin
        tick = 1;
        @(negedge clk) tick = 0;
        chk("req_after_tick", o_req, 1);
      end
      ack = 1;
      @(negedge clk) ack = 0;
    end
    if (exp_sel.size() > 0) chk("req_drop", o_req, 0);
  endtask

  task automatic do_start(input int len_exp);
    start = 1;
    @(negedge clk) start = 0;
    chk("init_body", o_init, 1);
    @(negedge clk);
    chk("init_len", o_len, len_exp);
    chk("init_over", o_ov, 0);
    chk("init_win", o_win, 0);
    chk("init_once", o_init, 0);
  endtask

  task automatic no_check(input string nm);
    repeat (3) begin
      @(negedge clk);
      chk(nm, o_chk, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t1[6];
    vec_t t2[2];
    // bad g1 g2 | mv grow len over win nreq
    t1[0] = '{0, 0, 0, 1, 0, 2, 0, 0, 0};
    t1[1] = '{0, 1, 0, 1, 1, 3, 0, 0, 1};
    t1[2] = '{0, 1, 1, 1, 1, 5, 0, 0, 2};
    t1[3] = '{0, 0, 1, 1, 1, 6, 0, 0, 1};
    t1[4] = '{0, 0, 0, 1, 0, 6, 0, 0, 0};
    t1[5] = '{1, 1, 0, 0, 0, 6, 1, 0, 0};
    t2[0] = '{0, 1, 0, 1, 1, 3, 0, 0, 1};
    t2[1] = '{0, 1, 1, 1, 1, 4, 1, 1, 0};

    repeat (3) @(negedge clk);
    chk("rst_chk", o_chk, 0);
    chk("rst_init", o_init, 0);
    chk("rst_mv", o_mv, 0);
    chk("rst_grow", o_grow, 0);
    chk("rst_req", o_req, 0);
    chk("rst_ov", o_ov, 0);
    chk("rst_win", o_win, 0);
    chk("rst_ovr", o_ovr, 0);
    chk("rst_len", o_len, 2);
    nrst = 1;
    @(negedge clk);
    tick = 1;
    @(negedge clk) tick = 0;
    no_check("idle_tick");
    mon_on = 1;

    do_start(2);
    for (int i = 0; i < 6; i++) run_step(t1[i], 0, 0);

    tick = 1;
    @(negedge clk) tick = 0;
    no_check("over_tick");
    chk("over_hold", o_ov, 1);
    chk("over_len", o_len, 6);
    do_start(2);

    start = 1; tick = 1;
    @(negedge clk) start = 0; tick = 0;
    chk("prio_init", o_init, 1);
    chk("prio_chk", o_chk, 0);
    no_check("prio_nochk");

    ack = 1;
    @(negedge clk) ack = 0;
    chk("stray_ack_req", o_req, 0);
    chk("ovr_clear", o_ovr, 0);
    run_step('{0, 1, 0, 1, 1, 3, 0, 0, 1}, 1, 0);
    chk("ovr_set", o_ovr, 1);
    no_check("ovr_dropped");
    run_step('{0, 0, 0, 1, 0, 3, 0, 0, 0}, 0, 0);
    chk("ovr_sticky", o_ovr, 1);
    run_step('{0, 0, 1, 1, 1, 4, 0, 0, 1}, 0, 1);
    tick = 1;
    @(negedge clk) tick = 0;
    no_check("post_rst_idle");
    chk("post_rst_len", o_len, 2);

    sel2 = 1;
    @(negedge clk);
    do_start(2);
    for (int i = 0; i < 2; i++) run_step(t2[i], 0, 0);
    @(negedge clk);
    chk("win_hold", o_win, 1);
    chk("win_over", o_ov, 1);
    chk("win_len", o_len, 4);
    tick = 1;
    @(negedge clk) tick = 0;
    no_check("win_tick");
    do_start(2);

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
